// File: rtl/jtopl_timers_if.sv
// Timer control and status bundle between the register map (master) and the
// Timer A/B block (slave).
interface jtopl_timers_if;
  logic       cenop_i;
  logic       zero_i;
  logic [7:0] value_a_i;
  logic [7:0] value_b_i;
  logic       load_a_i;
  logic       load_b_i;
  logic       flagen_a_i;
  logic       flagen_b_i;
  logic       clr_flag_a_i;
  logic       clr_flag_b_i;
  logic       flag_a_o;
  logic       flag_b_o;
  logic       overflow_a_o;
  logic       irq_n_o;
  logic [7:0] status_o;

  modport master (
    output cenop_i, zero_i, value_a_i, value_b_i, load_a_i, load_b_i,
           flagen_a_i, flagen_b_i, clr_flag_a_i, clr_flag_b_i,
    input  flag_a_o, flag_b_o, overflow_a_o, irq_n_o, status_o
  );

  modport slave (
    input  cenop_i, zero_i, value_a_i, value_b_i, load_a_i, load_b_i,
           flagen_a_i, flagen_b_i, clr_flag_a_i, clr_flag_b_i,
    output flag_a_o, flag_b_o, overflow_a_o, irq_n_o, status_o
  );
endinterface

// File: rtl/jtopl_timers.sv
// OPL Timer A / Timer B: two 8-bit up-counters stepped from a shared sample-tick
// prescaler, with per-timer flags, a registered IRQ and the status byte.
module jtopl_timers #(
  parameter int unsigned PRE_A = 4,
  parameter int unsigned PRE_B = 16  // power of two, multiple of PRE_A
) (
  input logic              clk,
  input logic              rst,
  jtopl_timers_if.slave    tmr
);

  localparam int PW = $clog2(PRE_B);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   presc_ext;
  logic          tick, step_a, step_b;

  logic [7:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic          load_a_prev_q, load_b_prev_q;
  logic          rise_a, rise_b, ovf_a, ovf_b;

  logic          flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic          ovf_a_q;
  logic          irq_n_q;

  assign tick      = tmr.cenop_i & tmr.zero_i;
  assign presc_ext = 32'(presc_q);
  assign presc_d   = (presc_q == PW'(PRE_B - 1)) ? '0 : presc_q + PW'(1);
  assign step_a    = tick & ((presc_ext % PRE_A) == (PRE_A - 1));
  assign step_b    = tick & (presc_q == PW'(PRE_B - 1));

  // A rising load edge reloads the counter and swallows any step in that cycle.
  assign rise_a = tmr.load_a_i & ~load_a_prev_q;
  assign rise_b = tmr.load_b_i & ~load_b_prev_q;
  assign ovf_a  = tmr.load_a_i & ~rise_a & step_a & (cnt_a_q == 8'hFF);
  assign ovf_b  = tmr.load_b_i & ~rise_b & step_b & (cnt_b_q == 8'hFF);

  always_comb begin
    cnt_a_d = cnt_a_q;
    if (rise_a) begin
      cnt_a_d = tmr.value_a_i;
    end else if (tmr.load_a_i && step_a) begin
      cnt_a_d = (cnt_a_q == 8'hFF) ? tmr.value_a_i : cnt_a_q + 8'd1;
    end
  end

  always_comb begin
    cnt_b_d = cnt_b_q;
    if (rise_b) begin
      cnt_b_d = tmr.value_b_i;
    end else if (tmr.load_b_i && step_b) begin
      cnt_b_d = (cnt_b_q == 8'hFF) ? tmr.value_b_i : cnt_b_q + 8'd1;
    end
  end

  // Set beats clear so an overflow coinciding with a clear is never lost.
  always_comb begin
    flag_a_d = flag_a_q;
    if (ovf_a && tmr.flagen_a_i) begin
      flag_a_d = 1'b1;
    end else if (tmr.clr_flag_a_i) begin
      flag_a_d = 1'b0;
    end
  end

  always_comb begin
    flag_b_d = flag_b_q;
    if (ovf_b && tmr.flagen_b_i) begin
      flag_b_d = 1'b1;
    end else if (tmr.clr_flag_b_i) begin
      flag_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      cnt_a_q       <= 8'h00;
      cnt_b_q       <= 8'h00;
      load_a_prev_q <= 1'b0;
      load_b_prev_q <= 1'b0;
      ovf_a_q       <= 1'b0;
      flag_a_q      <= 1'b0;
      flag_b_q      <= 1'b0;
      irq_n_q       <= 1'b1;
    end else begin
      if (tick) begin
        presc_q <= presc_d;
      end
      if (tmr.cenop_i) begin
        load_a_prev_q <= tmr.load_a_i;
        load_b_prev_q <= tmr.load_b_i;
        cnt_a_q       <= cnt_a_d;
        cnt_b_q       <= cnt_b_d;
        ovf_a_q       <= ovf_a;
      end
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      irq_n_q  <= ~(flag_a_q | flag_b_q);
    end
  end

  assign tmr.flag_a_o     = flag_a_q;
  assign tmr.flag_b_o     = flag_b_q;
  assign tmr.overflow_a_o = ovf_a_q;
  assign tmr.irq_n_o      = irq_n_q;
  assign tmr.status_o     = {~irq_n_q, flag_a_q, flag_b_q, 5'b00000};

endmodule

// File: tb/tb_jtopl_timers.sv
// Directed bench for jtopl_timers (PRE_A=4, PRE_B=16) with hand-computed
// tick counts; cenop=zero=1 gives one sample tick per clk unless noted.
module tb_jtopl_timers;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n;
  logic saw_a;

  jtopl_timers_if tif();

  jtopl_timers #(.PRE_A(4), .PRE_B(16)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tif.cenop_i = 1'b1;
    tif.zero_i = 1'b1;
    tif.value_a_i = 8'h00;
    tif.value_b_i = 8'h00;
    tif.load_a_i = 1'b0;
    tif.load_b_i = 1'b0;
    tif.flagen_a_i = 1'b0;
    tif.flagen_b_i = 1'b0;
    tif.clr_flag_a_i = 1'b0;
    tif.clr_flag_b_i = 1'b0;
    clk_n(1);
    rst = 1'b0;
  endtask

  // sel: 0 = overflow_A, 1 = flag_B, 2 = flag_A. Bounded by limit clocks.
  task automatic wait_for(input int sel, input int limit, output int cnt, output logic saw);
    logic hit;
    cnt = 0;
    saw = 1'b0;
    hit = 1'b0;
    while (!hit && cnt < limit) begin
      @(posedge clk);
      #1;
      cnt++;
      case (sel)
        0:       hit = tif.overflow_a_o;
        1:       hit = tif.flag_b_o;
        default: hit = tif.flag_a_o;
      endcase
      if (!hit && tif.overflow_a_o) saw = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Timer A period with value FE
    reset_dut();
    check("rst_irq_n", 32'(tif.irq_n_o), 32'd1);
    check("rst_status", 32'(tif.status_o), 32'h00);
    tif.value_a_i = 8'hFE;
    tif.load_a_i = 1'b1;
    tif.flagen_a_i = 1'b1;
    wait_for(0, 50, n, saw_a);
    check("a_first_ovf_clks", 32'(n), 32'd8);
    check("a_flag_set", 32'(tif.flag_a_o), 32'd1);
    check("a_irq_lag", 32'(tif.irq_n_o), 32'd1);
    check("a_status_lag", 32'(tif.status_o), 32'h40);
    clk_n(1);
    check("a_irq_low", 32'(tif.irq_n_o), 32'd0);
    check("a_status", 32'(tif.status_o), 32'hC0);
    check("a_ovf_one_period", 32'(tif.overflow_a_o), 32'd0);
    wait_for(0, 50, n, saw_a);
    check("a_second_ovf_clks", 32'(n), 32'd7);

    // Async reset mid-count with flag_A and overflow_A high
    check("pre_rst_ovf", 32'(tif.overflow_a_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_flag_a", 32'(tif.flag_a_o), 32'd0);
    check("arst_flag_b", 32'(tif.flag_b_o), 32'd0);
    check("arst_ovf_a", 32'(tif.overflow_a_o), 32'd0);
    check("arst_irq_n", 32'(tif.irq_n_o), 32'd1);
    check("arst_status", 32'(tif.status_o), 32'h00);

    // Timer B period with value F0: 16 steps of 16 ticks
    reset_dut();
    tif.value_b_i = 8'hF0;
    tif.load_b_i = 1'b1;
    tif.flagen_b_i = 1'b1;
    wait_for(1, 400, n, saw_a);
    check("b_first_ovf_clks", 32'(n), 32'd256);
    check("b_no_ovf_a", 32'(saw_a | tif.overflow_a_o), 32'd0);
    clk_n(1);
    check("b_status", 32'(tif.status_o), 32'hA0);
    check("b_irq_low", 32'(tif.irq_n_o), 32'd0);
    tif.cenop_i = 1'b0;
    tif.clr_flag_b_i = 1'b1;
    clk_n(1);
    tif.clr_flag_b_i = 1'b0;
    check("b_clr_no_cenop", 32'(tif.flag_b_o), 32'd0);
    check("b_status_irq_lag", 32'(tif.status_o), 32'h80);
    clk_n(1);
    check("b_irq_released", 32'(tif.irq_n_o), 32'd1);
    check("b_status_clear", 32'(tif.status_o), 32'h00);
    tif.cenop_i = 1'b1;

    // Masking with value FF: overflow every step, flag blocked
    reset_dut();
    tif.value_a_i = 8'hFF;
    tif.load_a_i = 1'b1;
    wait_for(0, 50, n, saw_a);
    check("mask_first_ovf_clks", 32'(n), 32'd4);
    check("mask_flag_blocked", 32'(tif.flag_a_o), 32'd0);
    clk_n(1);
    wait_for(0, 50, n, saw_a);
    check("mask_period_clks", 32'(n), 32'd3);
    check("mask_flag_still0", 32'(tif.flag_a_o), 32'd0);
    tif.cenop_i = 1'b0;
    clk_n(3);
    check("ovf_holds_no_cenop", 32'(tif.overflow_a_o), 32'd1);
    tif.cenop_i = 1'b1;
    tif.flagen_a_i = 1'b1;
    clk_n(1);
    check("ovf_drops", 32'(tif.overflow_a_o), 32'd0);
    wait_for(2, 50, n, saw_a);
    check("unmask_flag_clks", 32'(n), 32'd3);

    // Clear versus set
    tif.clr_flag_a_i = 1'b1;
    clk_n(1);
    tif.clr_flag_a_i = 1'b0;
    check("clr_plain", 32'(tif.flag_a_o), 32'd0);
    clk_n(2);
    tif.clr_flag_a_i = 1'b1;
    clk_n(1);
    tif.clr_flag_a_i = 1'b0;
    check("clr_set_same_ovf", 32'(tif.overflow_a_o), 32'd1);
    check("clr_set_wins", 32'(tif.flag_a_o), 32'd1);
    tif.flagen_a_i = 1'b0;
    clk_n(1);
    check("flagen0_keeps_flag", 32'(tif.flag_a_o), 32'd1);
    check("clr_irq_low", 32'(tif.irq_n_o), 32'd0);
    tif.clr_flag_a_i = 1'b1;
    clk_n(1);
    tif.clr_flag_a_i = 1'b0;
    check("clr_later", 32'(tif.flag_a_o), 32'd0);
    clk_n(1);
    check("clr_irq_high", 32'(tif.irq_n_o), 32'd1);
    check("clr_status", 32'(tif.status_o), 32'h00);
    clk_n(1);
    check("masked_ovf_again", 32'(tif.overflow_a_o), 32'd1);
    check("masked_flag_low", 32'(tif.flag_a_o), 32'd0);

    // Stop at cnt 80, rewrite value, restart from 10
    reset_dut();
    tif.value_a_i = 8'h7F;
    tif.load_a_i = 1'b1;
    tif.flagen_a_i = 1'b1;
    clk_n(4);
    tif.load_a_i = 1'b0;
    tif.value_a_i = 8'h10;
    clk_n(10);
    check("stop_no_ovf", 32'(tif.overflow_a_o), 32'd0);
    check("stop_no_flag", 32'(tif.flag_a_o), 32'd0);
    tif.load_a_i = 1'b1;
    wait_for(0, 1200, n, saw_a);
    check("restart_ovf_clks", 32'(n), 32'd958);
    check("restart_flag", 32'(tif.flag_a_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
